// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the load/store bus controller: FSM states,
// mem_mode encodings and the lane/alignment helpers used to build bus requests.
package mem_access_ctrl_pkg;

    localparam int TIMEOUT_DEF = 16;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b011;
    localparam logic [2:0] MEM_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Legal mode and natural alignment for its access size.
    function automatic logic access_ok(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            MEM_B, MEM_BU: access_ok = 1'b1;
            MEM_H, MEM_HU: access_ok = ~off[0];
            MEM_W:         access_ok = (off == 2'b00);
            default:       access_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            MEM_B, MEM_BU: lane_be = 4'b0001 << off;
            MEM_H, MEM_HU: lane_be = 4'b0011 << off;
            default:       lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] mode, input logic [31:0] wdata);
        case (mode)
            MEM_B, MEM_BU: lane_data = {4{wdata[7:0]}};
            MEM_H, MEM_HU: lane_data = {2{wdata[15:0]}};
            default:       lane_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it according to the load mode.
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(raw >> {off, 3'b000});
        half_sel = off[1] ? raw[31:16] : raw[15:0];
        case (mode)
            MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  data = {24'h0, byte_sel};
            MEM_H:   data = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  data = {16'h0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the core's decoder/ALU and a req/gnt/rvalid
// memory bus: stalls the core for the transaction, formats loads, flags faults/timeouts.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        err_timeout,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    mode_q;
    logic [1:0]    off_q;
    logic [31:0]   ld_data;
    logic          go, ok, complete, tmo_hit;

    assign go       = rd_en | wr_en;
    assign ok       = access_ok(mem_mode, addr[1:0]);
    assign complete = m_rvalid && ((state == WAIT) || (state == REQ && m_gnt));
    assign tmo_hit  = (cnt == CW'(TIMEOUT - 1));

    // The IDLE term lets the core freeze in the same cycle the request is seen.
    assign stall = (state == REQ) || (state == WAIT) || (state == IDLE && go && ok);

    load_align u_align (
        .mode (mode_q),
        .off  (off_q),
        .raw  (m_rdata),
        .data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            mode_q      <= MEM_W;
            off_q       <= 2'b00;
            rdata       <= '0;
            fault       <= 1'b0;
            err_timeout <= 1'b0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_be        <= '0;
            m_wdata     <= '0;
        end else begin
            fault       <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && ok) begin
                        state   <= REQ;
                        cnt     <= '0;
                        m_req   <= 1'b1;
                        m_we    <= wr_en;
                        we_q    <= wr_en;
                        mode_q  <= mem_mode;
                        off_q   <= addr[1:0];
                        m_addr  <= {addr[31:2], 2'b00};
                        m_be    <= lane_be(mem_mode, addr[1:0]);
                        m_wdata <= lane_data(mem_mode, wdata);
                    end else if (go) begin
                        fault <= 1'b1;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A response in the last allowed cycle still counts as success.
                    if (complete) begin
                        state <= DONE;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        if (!we_q)
                            rdata <= ld_data;
                    end else if (tmo_hit) begin
                        state       <= DONE;
                        m_req       <= 1'b0;
                        m_we        <= 1'b0;
                        err_timeout <= 1'b1;
                        rdata       <= '0;
                    end else if (state == REQ && m_gnt) begin
                        state <= WAIT;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver pushes expected completions and
// bus requests from a simple arithmetic model; a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [2:0]  mem_mode;
    logic [31:0] addr, wdata;
    logic        stall, fault, err_timeout;
    logic [31:0] rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .mem_mode(mem_mode),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .fault(fault),
        .err_timeout(err_timeout), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_be(m_be), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        bit          tmo;
        logic [31:0] rd;
        int          stall_len;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with empty expectation queue at %0t", name, $time);
    endtask

    // ---- reference model: plain size/offset arithmetic ----
    function automatic int acc_size(input int mode);
        if (mode == 0 || mode == 3) return 1;
        if (mode == 1 || mode == 4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input int mode, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> ((a % 4) * 8);
        case (mode)
            0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3: v = v & 32'hFF;
            1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            4: v = v & 32'hFFFF;
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input int mode, input logic [31:0] wd);
        logic [31:0] b, h;
        b = wd & 32'hFF;
        h = wd & 32'hFFFF;
        case (acc_size(mode))
            1: return b * 32'h01010101;
            2: return h * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // One decoder request plus the bus responder behaviour for it.
    task automatic txn(input bit we, input bit re, input int mode, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] raw,
                       input int gd, input int rd, input bit tmo);
        exp_t e;
        bus_t b;
        int   sz;
        bit   legal;
        sz    = acc_size(mode);
        legal = (mode < 5) && ((a % sz) == 0);
        e.is_fault = !legal;
        e.tmo      = legal && tmo;
        e.stall_len = tmo ? TO + 1 : gd + rd + 2;
        if (legal) begin
            if (tmo)     last_rdata = 0;
            else if (!we) last_rdata = ref_load(mode, a, raw);
        end
        e.rd = last_rdata;
        exp_q.push_back(e);
        if (legal && !tmo) begin
            b.we   = we;
            b.addr = a & 32'hFFFFFFFC;
            b.be   = 4'(((1 << sz) - 1) << (a % 4));
            b.wd   = ref_wdata(mode, wd);
            bus_q.push_back(b);
        end

        @(posedge clk); #1;
        rd_en = re; wr_en = we; mem_mode = 3'(mode); addr = a; wdata = wd;
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0; mem_mode = 3'($urandom); addr = $urandom; wdata = $urandom;

        if (!legal) begin
            chk("fault_no_req", {31'b0, m_req}, 0);
            repeat (2) @(posedge clk);
            return;
        end
        if (tmo) begin
            chk("tmo_req_high", {31'b0, m_req}, 1);
            repeat (TO) @(posedge clk);
            #1 chk("tmo_req_dropped", {31'b0, m_req}, 0);
            @(posedge clk);
            return;
        end
        repeat (gd) @(posedge clk);
        #1;
        m_gnt = 1; m_rvalid = (rd == 0); m_rdata = raw;
        @(posedge clk); #1;
        m_gnt = 0; m_rvalid = 0; m_rdata = $urandom;
        if (rd > 0) begin
            repeat (rd - 1) @(posedge clk);
            #1;
            m_rvalid = 1; m_rdata = raw;
            @(posedge clk); #1;
            m_rvalid = 0; m_rdata = $urandom;
        end
        @(posedge clk);
    endtask

    // ---- monitor ----
    initial begin : monitor
        int   run;
        exp_t e;
        bus_t b;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (fault) begin
                    if (exp_q.size() == 0) fail_now("fault_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("fault_kind", {31'b0, e.is_fault}, 1);
                        chk("fault_stall", {31'b0, stall}, 0);
                    end
                end
                if (stall) run++;
                else if (run > 0) begin
                    if (exp_q.size() == 0) fail_now("done_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("done_kind", {31'b0, e.is_fault}, 0);
                        chk("stall_len", run, e.stall_len);
                        chk("rdata", rdata, e.rd);
                        chk("err_timeout", {31'b0, err_timeout}, {31'b0, e.tmo});
                    end
                    run = 0;
                end
                if (m_req && m_gnt) begin
                    if (bus_q.size() == 0) fail_now("bus_unexpected");
                    else begin
                        b = bus_q.pop_front();
                        chk("m_we", {31'b0, m_we}, {31'b0, b.we});
                        chk("m_addr", m_addr, b.addr);
                        chk("m_be", {28'b0, m_be}, {28'b0, b.be});
                        if (b.we) chk("m_wdata", m_wdata, b.wd);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- stimulus ----
    initial begin : driver
        bus_t b;
        rst_n = 0; rd_en = 0; wr_en = 0; mem_mode = 0; addr = 0; wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_m_req", {31'b0, m_req}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_be", {28'b0, m_be}, 0);
        rst_n = 1;

        // directed cases
        txn(0, 1, 2, 32'h100, 0, 32'hDEADBEEF, 1, 1, 0);
        txn(0, 1, 0, 32'h103, 0, 32'h80FFFF7F, 0, 2, 0);
        txn(0, 1, 3, 32'h103, 0, 32'h80FFFF7F, 2, 0, 0);
        txn(1, 0, 1, 32'h202, 32'h1234ABCD, 32'h0, 2, 1, 0);
        txn(0, 1, 2, 32'h101, 0, 32'h0, 0, 0, 0);
        txn(0, 1, 5, 32'h100, 0, 32'h0, 0, 0, 0);
        txn(0, 1, 2, 32'h300, 0, 32'h12345678, 0, 0, 1);
        txn(0, 1, 4, 32'h402, 0, 32'h8001_7FFF, 0, 0, 0);

        // reset in WAIT, then a stale response after release
        b.we = 0; b.addr = 32'h400; b.be = 4'hF; b.wd = 0;
        bus_q.push_back(b);
        @(posedge clk); #1;
        rd_en = 1; mem_mode = 3'd2; addr = 32'h400;
        @(posedge clk); #1;
        rd_en = 0; m_gnt = 1;
        @(posedge clk); #1;
        m_gnt = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_stall", {31'b0, stall}, 0);
        chk("async_rst_m_req", {31'b0, m_req}, 0);
        chk("async_rst_m_addr", m_addr, 0);
        chk("async_rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1; last_rdata = 0;
        m_rvalid = 1; m_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        m_rvalid = 0;
        chk("late_rvalid_stall", {31'b0, stall}, 0);
        chk("late_rvalid_m_req", {31'b0, m_req}, 0);
        @(posedge clk); #1;
        chk("late_rvalid_rdata", rdata, 0);
        chk("late_rvalid_idle", {31'b0, stall}, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int          mode, sel, sz;
            logic [31:0] a;
            bit          tmo;
            mode = $urandom_range(0, 7);
            sz   = acc_size(mode);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 1);
            sel  = $urandom_range(0, 4);
            tmo  = ($urandom_range(0, 9) == 0);
            txn(sel >= 2, sel != 2, mode, a, $urandom, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 4), tmo);
        end

        repeat (3) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
